// File: rtl/bin_pkg.sv
// Shared constants and types for the binarizer datapath and its threshold controller.
// Latency: n/a (declarations and one pure combinational helper).
// Backpressure: n/a.
package bin_pkg;

  localparam int PIX_W = 8;
  localparam int THR_W = 8;

  localparam logic [THR_W-1:0] DEF_THRESH = 8'd127;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Midpoint of two pixels; the sum is formed in PIX_W+1 bits so 255+255 cannot wrap.
  function automatic logic [THR_W-1:0] mid_point(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_W:1];
  endfunction

endpackage

// File: rtl/bin_thr_ctrl_if.sv
// Pixel tap, configuration and status bundle between the pixel source/CPU side and bin_thr_ctrl.
// Latency: n/a (wires only).
// Backpressure: none; the pixel tap is observe-only and is never stalled.
// Ports (master drives / slave receives):
//   gus_din/gus_valid/gus_sop/gus_eop : filtered pixel stream tap
//   cfg_wr/cfg_thresh/cfg_auto        : manual threshold write strobe/value, auto-mode select
//   err_clr                           : clears sticky error flags
//   thr_out/frame_active/frame_done   : threshold and frame status (driven by slave)
//   err_sop/err_eop/err_len           : sticky framing errors (driven by slave)
interface bin_thr_ctrl_if;
  import bin_pkg::*;

  logic [PIX_W-1:0] gus_din;
  logic             gus_valid;
  logic             gus_sop;
  logic             gus_eop;
  logic             cfg_wr;
  logic [THR_W-1:0] cfg_thresh;
  logic             cfg_auto;
  logic             err_clr;
  logic [THR_W-1:0] thr_out;
  logic             frame_active;
  logic             frame_done;
  logic             err_sop;
  logic             err_eop;
  logic             err_len;

  modport master (
    output gus_din, gus_valid, gus_sop, gus_eop,
    output cfg_wr, cfg_thresh, cfg_auto, err_clr,
    input  thr_out, frame_active, frame_done, err_sop, err_eop, err_len
  );

  modport slave (
    input  gus_din, gus_valid, gus_sop, gus_eop,
    input  cfg_wr, cfg_thresh, cfg_auto, err_clr,
    output thr_out, frame_active, frame_done, err_sop, err_eop, err_len
  );

endinterface

// File: rtl/bin_minmax.sv
// Running min/max of the pixels of one frame, plus the min/max merged with the current pixel.
// Latency: stored min/max update one cycle after i_upd; merged outputs are combinational.
// Backpressure: none; acts on every cycle its controls are asserted.
// Ports: i_clr (return to empty FF/00), i_upd (fold i_din in), i_clr&i_upd (restart from i_din),
//        o_min/o_max stored values, o_min_m/o_max_m stored values merged with i_din.
module bin_minmax
  import bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_upd,
  input  logic [PIX_W-1:0] i_din,
  output logic [PIX_W-1:0] o_min,
  output logic [PIX_W-1:0] o_max,
  output logic [PIX_W-1:0] o_min_m,
  output logic [PIX_W-1:0] o_max_m
);

  logic [PIX_W-1:0] r_min;
  logic [PIX_W-1:0] r_max;

  // Merged values let the frame-closing pixel be included without waiting a cycle.
  assign o_min_m = (i_din < r_min) ? i_din : r_min;
  assign o_max_m = (i_din > r_max) ? i_din : r_max;
  assign o_min   = r_min;
  assign o_max   = r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_clr && i_upd) begin
      r_min <= i_din;
      r_max <= i_din;
    end else if (i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_upd) begin
      r_min <= o_min_m;
      r_max <= o_max_m;
    end
  end

endmodule

// File: rtl/bin_thr_ctrl.sv
// Frame-tracking threshold controller: picks the binarizer threshold (auto midpoint or manual) per frame.
// Latency: thr_out/frame_done/error flags update on the edge after the closing eop pixel (1 cycle).
// Backpressure: none; observes the pixel stream and never stalls it.
// Ports: clk, rst_n (async, active-low) plain; everything else via bin_thr_ctrl_if.slave (bus):
//   pixel tap in, cfg_wr/cfg_thresh/cfg_auto/err_clr in, thr_out/frame_active/frame_done/err_* out.
module bin_thr_ctrl #(
  parameter int                        IMG_W      = 640,
  parameter int                        IMG_H      = 480,
  parameter logic [bin_pkg::THR_W-1:0] DEF_THRESH = bin_pkg::DEF_THRESH
) (
  input  logic           clk,
  input  logic           rst_n,
  bin_thr_ctrl_if.slave  bus
);
  import bin_pkg::*;

  localparam int PIX_CNT = IMG_W * IMG_H;
  // Wide enough to hold the saturation value PIX_CNT+1.
  localparam int CW      = $clog2(PIX_CNT + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(PIX_CNT);
  localparam logic [CW-1:0] CNT_SAT  = CW'(PIX_CNT + 1);

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_auto;
  logic [THR_W-1:0] r_pend;
  logic [THR_W-1:0] r_thr;
  logic             r_active;
  logic             r_done;
  logic             r_err_sop;
  logic             r_err_eop;
  logic             r_err_len;

  logic             w_sop;
  logic             w_eop;
  logic             w_in_act;
  logic             w_single;
  logic             w_close;
  logic             w_start;
  logic             w_plain;
  logic [CW-1:0]    w_cnt_inc;
  logic [CW-1:0]    w_close_cnt;
  logic             w_good;
  logic             w_close_auto;
  logic [PIX_W-1:0] w_mm_min;
  logic [PIX_W-1:0] w_mm_max;
  logic [PIX_W-1:0] w_mm_min_m;
  logic [PIX_W-1:0] w_mm_max_m;
  logic [PIX_W-1:0] w_fmin;
  logic [PIX_W-1:0] w_fmax;
  logic [THR_W-1:0] w_avg;

  assign w_sop    = bus.gus_valid & bus.gus_sop;
  assign w_eop    = bus.gus_valid & bus.gus_eop;
  assign w_in_act = (r_state == ST_ACTIVE);

  // sop+eop together is a complete one-pixel frame in either state; in ACTIVE it also
  // discards the partial frame before it.
  assign w_single = w_sop & w_eop;
  assign w_close  = w_eop & (w_in_act | w_sop);
  assign w_start  = w_sop & ~w_eop;
  assign w_plain  = w_in_act & bus.gus_valid & ~bus.gus_sop & ~bus.gus_eop;

  assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;
  assign w_close_cnt = w_single ? CW'(1) : w_cnt_inc;
  assign w_good      = w_close & (w_close_cnt == CNT_FULL);

  // A frame closing on its own sop pixel uses the mode presented with that sop.
  assign w_close_auto = w_sop ? bus.cfg_auto : r_auto;

  assign w_fmin = w_single ? bus.gus_din : w_mm_min_m;
  assign w_fmax = w_single ? bus.gus_din : w_mm_max_m;
  assign w_avg  = mid_point(w_fmin, w_fmax);

  bin_minmax u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_close | w_start),
    .i_upd   (w_start | w_plain),
    .i_din   (bus.gus_din),
    .o_min   (w_mm_min),
    .o_max   (w_mm_max),
    .o_min_m (w_mm_min_m),
    .o_max_m (w_mm_max_m)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_auto    <= 1'b0;
      r_pend    <= DEF_THRESH;
      r_thr     <= DEF_THRESH;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_err_sop <= 1'b0;
      r_err_eop <= 1'b0;
      r_err_len <= 1'b0;
    end else begin
      r_done <= w_close;

      if (bus.cfg_wr) r_pend <= bus.cfg_thresh;

      // Error set beats a coincident clear.
      r_err_sop <= (w_sop & w_in_act)             | (r_err_sop & ~bus.err_clr);
      r_err_eop <= (w_eop & ~w_in_act & ~w_sop)   | (r_err_eop & ~bus.err_clr);
      r_err_len <= (w_close & ~w_good)            | (r_err_len & ~bus.err_clr);

      // Threshold only moves between frames so a frame is binarized with one value.
      if (w_good) begin
        if (w_close_auto)    r_thr <= w_avg;
        else if (bus.cfg_wr) r_thr <= bus.cfg_thresh;
        else                 r_thr <= r_pend;
      end else if (bus.cfg_wr && !w_in_act && !w_sop) begin
        r_thr <= bus.cfg_thresh;
      end

      if (w_close) begin
        r_state  <= ST_IDLE;
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else if (w_start) begin
        r_state  <= ST_ACTIVE;
        r_active <= 1'b1;
        r_cnt    <= CW'(1);
        r_auto   <= bus.cfg_auto;
      end else if (w_plain) begin
        r_cnt    <= w_cnt_inc;
      end
    end
  end

  assign bus.thr_out      = r_thr;
  assign bus.frame_active = r_active;
  assign bus.frame_done   = r_done;
  assign bus.err_sop      = r_err_sop;
  assign bus.err_eop      = r_err_eop;
  assign bus.err_len      = r_err_len;

endmodule

// File: tb/tb_bin_thr_ctrl.sv
// Directed bench for bin_thr_ctrl with a 4x2 image (8 pixels per frame).
module tb_bin_thr_ctrl;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  bin_thr_ctrl_if u_if ();

  bin_thr_ctrl #(
    .IMG_W      (4),
    .IMG_H      (2),
    .DEF_THRESH (8'd127)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic pix(input logic [7:0] d, input logic s, input logic e);
    u_if.gus_din   = d;
    u_if.gus_valid = 1'b1;
    u_if.gus_sop   = s;
    u_if.gus_eop   = e;
    tick();
    u_if.gus_valid = 1'b0;
    u_if.gus_sop   = 1'b0;
    u_if.gus_eop   = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic es, input logic ee, input logic el);
    chk({tag, "_err_sop"}, 32'(u_if.err_sop), 32'(es));
    chk({tag, "_err_eop"}, 32'(u_if.err_eop), 32'(ee));
    chk({tag, "_err_len"}, 32'(u_if.err_len), 32'(el));
  endtask

  logic [7:0] auto_px [8];

  initial begin
    passed = 0;
    total  = 0;
    auto_px = '{8'd10, 8'd200, 8'd50, 8'd60, 8'd70, 8'd80, 8'd40, 8'd90};
    rst_n           = 1'b0;
    u_if.gus_din    = '0;
    u_if.gus_valid  = 1'b0;
    u_if.gus_sop    = 1'b0;
    u_if.gus_eop    = 1'b0;
    u_if.cfg_wr     = 1'b0;
    u_if.cfg_thresh = '0;
    u_if.cfg_auto   = 1'b1;
    u_if.err_clr    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_thr", 32'(u_if.thr_out), 127);
    chk("rst_active", 32'(u_if.frame_active), 0);
    chk("rst_done", 32'(u_if.frame_done), 0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Auto good frame: min 10, max 200 -> 105
    for (int i = 0; i < 8; i++) begin
      pix(auto_px[i], i == 0, i == 7);
      if (i == 0) chk("auto_active_after_sop", 32'(u_if.frame_active), 1);
      if (i == 3) chk("auto_thr_mid", 32'(u_if.thr_out), 127);
    end
    chk("auto_thr", 32'(u_if.thr_out), 105);
    chk("auto_done", 32'(u_if.frame_done), 1);
    chk("auto_active_end", 32'(u_if.frame_active), 0);
    chk_flags("auto", 1'b0, 1'b0, 1'b0);
    tick();
    chk("auto_done_drop", 32'(u_if.frame_done), 0);

    // Manual frame, cfg_wr 60 mid-frame
    u_if.cfg_auto = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        u_if.cfg_wr     = 1'b1;
        u_if.cfg_thresh = 8'd60;
      end
      pix(8'(20 + i * 10), i == 0, i == 7);
      u_if.cfg_wr = 1'b0;
      if (i == 2 || i == 6) chk("man_thr_hold", 32'(u_if.thr_out), 105);
    end
    chk("man_thr_close", 32'(u_if.thr_out), 60);
    chk("man_done", 32'(u_if.frame_done), 1);
    u_if.cfg_wr     = 1'b1;
    u_if.cfg_thresh = 8'd80;
    tick();
    u_if.cfg_wr = 1'b0;
    chk("man_idle_wr", 32'(u_if.thr_out), 80);
    chk("man_idle_done", 32'(u_if.frame_done), 0);

    // Short frame of 7 pixels -> err_len, threshold unchanged
    for (int i = 0; i < 7; i++) pix(8'(5 + i), i == 0, i == 6);
    chk("short_thr", 32'(u_if.thr_out), 80);
    chk("short_done", 32'(u_if.frame_done), 1);
    chk_flags("short", 1'b0, 1'b0, 1'b1);
    u_if.err_clr = 1'b1;
    tick();
    u_if.err_clr = 1'b0;
    chk("short_clr", 32'(u_if.err_len), 0);

    // Restart: sop at pixel 5, then a clean 8-pixel auto frame 100..170 -> 135
    u_if.cfg_auto = 1'b1;
    pix(8'd0, 1'b1, 1'b0);
    pix(8'd255, 1'b0, 1'b0);
    pix(8'd5, 1'b0, 1'b0);
    pix(8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pix(8'(100 + i * 10), i == 0, i == 7);
      if (i == 0) begin
        chk("rs_err_sop", 32'(u_if.err_sop), 1);
        chk("rs_no_done", 32'(u_if.frame_done), 0);
        chk("rs_active", 32'(u_if.frame_active), 1);
      end
    end
    chk("rs_thr", 32'(u_if.thr_out), 135);
    chk("rs_done", 32'(u_if.frame_done), 1);
    chk_flags("rs", 1'b1, 1'b0, 1'b0);

    // Lone eop in IDLE with coincident err_clr: err_sop cleared, err_eop set
    u_if.err_clr = 1'b1;
    pix(8'd1, 1'b0, 1'b1);
    u_if.err_clr = 1'b0;
    chk_flags("eop", 1'b0, 1'b1, 1'b0);
    chk("eop_active", 32'(u_if.frame_active), 0);
    chk("eop_done", 32'(u_if.frame_done), 0);
    chk("eop_thr", 32'(u_if.thr_out), 135);

    // Reset mid-frame
    pix(8'd30, 1'b1, 1'b0);
    pix(8'd31, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_thr", 32'(u_if.thr_out), 127);
    chk("mrst_active", 32'(u_if.frame_active), 0);
    chk_flags("mrst", 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    pix(8'd32, 1'b0, 1'b1);
    chk_flags("post_rst_eop", 1'b0, 1'b1, 1'b0);
    chk("post_rst_done", 32'(u_if.frame_done), 0);

    // One-pixel frame (sop+eop in IDLE): closes immediately, wrong length
    u_if.err_clr = 1'b1;
    tick();
    u_if.err_clr = 1'b0;
    pix(8'd200, 1'b1, 1'b1);
    chk("one_done", 32'(u_if.frame_done), 1);
    chk("one_active", 32'(u_if.frame_active), 0);
    chk("one_thr", 32'(u_if.thr_out), 127);
    chk_flags("one", 1'b0, 1'b0, 1'b1);

    // 24-pixel frame: counter must saturate rather than wrap back to 8
    u_if.err_clr = 1'b1;
    tick();
    u_if.err_clr = 1'b0;
    for (int i = 0; i < 24; i++) pix(8'(i * 5), i == 0, i == 23);
    chk("sat_done", 32'(u_if.frame_done), 1);
    chk("sat_thr", 32'(u_if.thr_out), 127);
    chk_flags("sat", 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
